// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared state type and sizing helpers for the iterative Vedic multiplier
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Number of DIGIT-wide digits per operand.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Column index runs 0 .. 2K-2.
    function automatic int col_width(input int k);
        return $clog2(2 * k - 1);
    endfunction

    // A column holds up to K digit products, each 2*DIGIT bits wide.
    function automatic int sum_width(input int digit, input int k);
        return 2 * digit + $clog2(k);
    endfunction

endpackage

// File: rtl/vedic_column_sum.sv
// rtl/vedic_column_sum.sv - combinational Urdhva-Tiryakbhyam column sum S(col)
//
// Ports:
//   a_mag, b_mag : operand magnitudes, viewed as K digits of DIGIT bits
//   col          : column index 0 .. 2K-2
//   sum          : sum over i+j=col of a_i * b_j
module vedic_column_sum
    import vedic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8,
    localparam int K  = num_digits(WIDTH, DIGIT),
    localparam int CW = col_width(K),
    localparam int SW = sum_width(DIGIT, K)
) (
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    input  logic [CW-1:0]    col,
    output logic [SW-1:0]    sum
);

    // One multiplier per digit of a. Each picks the b digit whose index
    // pairs with it in this column; out-of-range pairings leave a zero digit,
    // so that multiplier contributes nothing.
    always_comb begin
        logic [DIGIT-1:0]   b_sel;
        logic [2*DIGIT-1:0] prod;
        sum = '0;
        for (int i = 0; i < K; i++) begin
            b_sel = '0;
            for (int j = 0; j < K; j++) begin
                if (int'(col) == i + j) begin
                    b_sel = b_mag[j*DIGIT +: DIGIT];
                end
            end
            prod = {{DIGIT{1'b0}}, a_mag[i*DIGIT +: DIGIT]} * {{DIGIT{1'b0}}, b_sel};
            sum  = sum + SW'(prod);
        end
    end

endmodule

// File: rtl/vedic_mult_iter.sv
// rtl/vedic_mult_iter.sv - iterative column-wise Vedic multiplier, one column per clock
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : request, accepted when ready
//   signed_mode  : 1 = two's complement operands (sampled with start)
//   a, b         : operands (sampled with start)
//   ready        : idle and able to accept start
//   busy         : computing (CALC or FIX)
//   result       : 2*WIDTH product, held until the next valid_out
//   valid_out    : one-cycle pulse when result updates
module vedic_mult_iter
    import vedic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8,
    localparam int K  = num_digits(WIDTH, DIGIT),
    localparam int CW = col_width(K),
    localparam int SW = sum_width(DIGIT, K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result,
    output logic                 valid_out
);

    localparam logic [CW-1:0] LAST_COL = CW'(2 * K - 2);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      col;
    logic [SW-1:0]      col_sum;

    // The most negative operand negates to itself, which read as unsigned
    // is exactly its magnitude 2^(WIDTH-1).
    assign a_abs = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_abs = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    vedic_column_sum #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_column_sum (
        .a_mag (mag_a),
        .b_mag (mag_b),
        .col   (col),
        .sum   (col_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (col == LAST_COL) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == CALC) || (state == FIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            col       <= '0;
            result    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_abs;
                        mag_b <= b_abs;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        col   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + ((2*WIDTH)'(col_sum) << (int'(col) * DIGIT));
                    col <= col + CW'(1);
                end
                FIX: begin
                    result    <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                    valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_mult_iter.sv
// tb/tb_vedic_mult_iter.sv - scoreboard bench for vedic_mult_iter at 32/8 and 16/4
module tb_vedic_mult_iter;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, sm32, start16, sm16;
    logic [31:0] a32, b32;
    logic [15:0] a16, b16;
    logic        ready32, busy32, valid32;
    logic        ready16, busy16, valid16;
    logic [63:0] result32;
    logic [31:0] result16;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    vedic_mult_iter #(.WIDTH(32), .DIGIT(8)) u_dut32 (
        .clk (clk), .reset (reset), .start (start32), .signed_mode (sm32),
        .a (a32), .b (b32), .ready (ready32), .busy (busy32),
        .result (result32), .valid_out (valid32)
    );

    vedic_mult_iter #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk (clk), .reset (reset), .start (start16), .signed_mode (sm16),
        .a (a16), .b (b16), .ready (ready16), .busy (busy16),
        .result (result16), .valid_out (valid16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input int w);
        logic signed [63:0] sx, sy;
        logic [63:0] p;
        if (s) begin
            sx = $signed(64'(x) << (64 - w)) >>> (64 - w);
            sy = $signed(64'(y) << (64 - w)) >>> (64 - w);
        end else begin
            sx = 64'(x);
            sy = 64'(y);
        end
        p = sx * sy;
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'd1 << w) - 32'd1);
        return v;
    endfunction

    // Scoreboards: pop on every valid_out, check value, latency and ready.
    always @(negedge clk) begin
        if (valid32 === 1'b1) begin
            if (q32.size() == 0) begin
                check("spurious_valid32", 64'(valid32), 64'd0);
            end else begin
                e32 = q32.pop_front();
                check("result32", result32, e32.res);
                check("latency32", 64'(cyc), 64'(e32.cyc));
                check("ready_at_valid32", 64'(ready32), 64'd1);
            end
        end
        if (valid16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("spurious_valid16", 64'(valid16), 64'd0);
            end else begin
                e16 = q16.pop_front();
                check("result16", 64'(result16), e16.res);
                check("latency16", 64'(cyc), 64'(e16.cyc));
            end
        end
    end

    // Call at a negedge; start is sampled at the next posedge.
    task automatic issue32(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t t;
        a32 = x; b32 = y; sm32 = s; start32 = 1'b1;
        if (ready32 && !reset) begin
            t.res = ref_mul(x, y, s, 32);
            t.cyc = cyc + 1 + 8;
            q32.push_back(t);
        end
        @(negedge clk);
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
    endtask

    task automatic issue16(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t t;
        a16 = x; b16 = y; sm16 = s; start16 = 1'b1;
        if (ready16 && !reset) begin
            t.res = ref_mul(32'(x), 32'(y), s, 16);
            t.cyc = cyc + 1 + 8;
            q16.push_back(t);
        end
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain;
        for (int n = 0; n < 100 && (q32.size() != 0 || q16.size() != 0); n++) @(negedge clk);
        if (q32.size() != 0) begin
            check("timeout32", 64'(q32.size()), 64'd0);
            q32.delete();
        end
        if (q16.size() != 0) begin
            check("timeout16", 64'(q16.size()), 64'd0);
            q16.delete();
        end
    endtask

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(negedge clk);
        issue32(x, y, s);
        wait_drain();
    endtask

    initial begin
        reset = 1'b1;
        start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready32), 64'd1);
        check("reset_busy", 64'(busy32), 64'd0);
        check("reset_valid", 64'(valid32), 64'd0);
        check("reset_result", result32, 64'd0);
        check("reset_ready16", 64'(ready16), 64'd1);
        reset = 1'b0;

        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("max_unsigned_value", result32, 64'hFFFF_FFFE_0000_0001);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("neg1_sq", result32, 64'h0000_0000_0000_0001);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1);
        check("min_sq", result32, 64'h4000_0000_0000_0000);
        run32(32'hFFFF_FFFD, 32'd5, 1'b1);
        check("m3x5", result32, 64'hFFFF_FFFF_FFFF_FFF1);
        run32(32'h8000_0000, 32'd1, 1'b1);
        check("min_x1", result32, 64'hFFFF_FFFF_8000_0000);
        run32(32'h8000_0000, 32'd2, 1'b0);
        check("u_min_x2", result32, 64'h0000_0001_0000_0000);
        run32(32'h8000_0000, 32'd2, 1'b1);
        check("s_min_x2", result32, 64'hFFFF_FFFF_0000_0000);

        // start while busy is ignored; start in the valid_out cycle is taken
        @(negedge clk);
        issue32(32'd7, 32'd6, 1'b0);
        repeat (2) @(negedge clk);
        a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int n = 0; n < 20 && !valid32; n++) @(negedge clk);
        check("first_valid_seen", 64'(valid32), 64'd1);
        check("busy_start_ignored", result32, 64'd42);
        issue32(32'd11, 32'd13, 1'b0);
        wait_drain();
        check("b2b_result", result32, 64'd143);

        // reset mid-operation aborts with no pulse
        @(negedge clk);
        issue32(32'h1234, 32'h5678, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q32.delete();
        check("abort_result", result32, 64'd0);
        check("abort_ready", 64'(ready32), 64'd1);
        check("abort_busy", 64'(busy32), 64'd0);
        repeat (12) @(negedge clk);
        run32(32'd0, 32'h1234_5678, 1'b0);
        check("zero_x", result32, 64'd0);

        for (int n = 0; n < 1000; n++) begin
            for (int w = 0; w < 20 && !ready32; w++) @(negedge clk);
            issue32(pick(32), pick(32), 1'($urandom_range(0, 1)));
        end
        wait_drain();

        for (int n = 0; n < 1000; n++) begin
            for (int w = 0; w < 20 && !ready16; w++) @(negedge clk);
            issue16(16'(pick(16)), 16'(pick(16)), 1'($urandom_range(0, 1)));
        end
        wait_drain();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
